// File: rtl/symres_pkg.sv
// Shared types and helpers for the symbol residue tracker: FSM state encoding
// and the residue-width calculation.
package symres_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/symbol_residue_tracker_if.sv
// Symbol input handshake, live residue view and frame-report handshake of the
// symbol residue tracker, bundled as one interface.
interface symbol_residue_tracker_if #(
    parameter int SYM_W = 1,
    parameter int MOD   = 2,
    parameter int LEN_W = 16
);
    import symres_pkg::*;

    localparam int NSYM = 1 << SYM_W;
    localparam int RW   = clog2(MOD);

    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [SYM_W-1:0]     in_sym;
    logic                 in_last;
    logic [NSYM*RW-1:0]   res_flat;
    logic [NSYM-1:0]      mod_zero;
    logic                 rpt_valid;
    logic                 rpt_ready;
    logic [NSYM-1:0]      rpt_zero;
    logic [NSYM*RW-1:0]   rpt_res;
    logic [LEN_W-1:0]     rpt_len;
    logic                 rpt_sat;

    modport master (
        output clear, in_valid, in_sym, in_last, rpt_ready,
        input  in_ready, res_flat, mod_zero,
        input  rpt_valid, rpt_zero, rpt_res, rpt_len, rpt_sat
    );

    modport slave (
        input  clear, in_valid, in_sym, in_last, rpt_ready,
        output in_ready, res_flat, mod_zero,
        output rpt_valid, rpt_zero, rpt_res, rpt_len, rpt_sat
    );

endinterface

// File: rtl/symres_cell.sv
// One modulo-MOD occurrence counter. Exposes both the held residue and the
// value it will take on an increment, so a frame snapshot can include the
// symbol being counted on the same edge.
module symres_cell
    import symres_pkg::*;
#(
    parameter int MOD = 2,
    localparam int RW = clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [RW-1:0] res,
    output logic [RW-1:0] res_nxt,
    output logic          is_zero,
    output logic          nxt_zero
);

    localparam logic [RW-1:0] TOP = RW'(MOD - 1);

    always_comb begin
        res_nxt = res;
        if (inc) res_nxt = (res == TOP) ? '0 : res + RW'(1);
    end

    assign is_zero  = (res == '0);
    assign nxt_zero = (res_nxt == '0);

    // NOTE: async reset in the sensitivity list, non-blocking updates only, so
    // every flop in the block samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   res <= '0;
        else if (clr) res <= '0;
        else          res <= res_nxt;
    end

endmodule

// File: rtl/symbol_residue_tracker.sv
// Serial symbol monitor: per-symbol occurrence count modulo MOD, frame length,
// and a held per-frame report with valid/ready handshake.
module symbol_residue_tracker
    import symres_pkg::*;
#(
    parameter int SYM_W = 1,
    parameter int MOD   = 2,
    parameter int LEN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    symbol_residue_tracker_if.slave  bus
);

    localparam int NSYM = 1 << SYM_W;
    localparam int RW   = clog2(MOD);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t               state;
    logic [LEN_W-1:0]     len;
    logic                 sat;
    logic                 accept;
    logic                 frame_end;
    logic                 len_full;
    logic [LEN_W-1:0]     len_nxt;
    logic [NSYM*RW-1:0]   res_cur;
    logic [NSYM*RW-1:0]   res_nxt;
    logic [NSYM-1:0]      zero_cur;
    logic [NSYM-1:0]      zero_nxt;
    logic                 rpt_valid_q;
    logic [NSYM-1:0]      rpt_zero_q;
    logic [NSYM*RW-1:0]   rpt_res_q;
    logic [LEN_W-1:0]     rpt_len_q;
    logic                 rpt_sat_q;

    assign bus.in_ready = (state != HOLD) & ~bus.clear;
    assign accept       = bus.in_valid & bus.in_ready;
    assign frame_end    = accept & bus.in_last;

    // An increment attempted while already all-ones marks the frame saturated.
    assign len_full = (len == LEN_MAX);
    assign len_nxt  = len_full ? len : len + LEN_W'(1);

    for (genvar i = 0; i < NSYM; i++) begin : g_cell
        symres_cell #(.MOD(MOD)) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (accept && (bus.in_sym == SYM_W'(i))),
            .clr      (bus.clear | frame_end),
            .res      (res_cur[i*RW +: RW]),
            .res_nxt  (res_nxt[i*RW +: RW]),
            .is_zero  (zero_cur[i]),
            .nxt_zero (zero_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len         <= '0;
            sat         <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_zero_q  <= '0;
            rpt_res_q   <= '0;
            rpt_len_q   <= '0;
            rpt_sat_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (bus.clear) begin
                        state <= IDLE;
                        len   <= '0;
                        sat   <= 1'b0;
                    end else if (frame_end) begin
                        rpt_res_q   <= res_nxt;
                        rpt_zero_q  <= zero_nxt;
                        rpt_len_q   <= len_nxt;
                        rpt_sat_q   <= sat | len_full;
                        rpt_valid_q <= 1'b1;
                        len         <= '0;
                        sat         <= 1'b0;
                        state       <= HOLD;
                    end else if (accept) begin
                        len   <= len_nxt;
                        sat   <= sat | len_full;
                        state <= RUN;
                    end
                end
                HOLD: begin
                    // Live state is cleared by clear; the pending report is not.
                    if (bus.clear) begin
                        len <= '0;
                        sat <= 1'b0;
                    end
                    if (bus.rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_flat  = res_cur;
    assign bus.mod_zero  = zero_cur;
    assign bus.rpt_valid = rpt_valid_q;
    assign bus.rpt_zero  = rpt_zero_q;
    assign bus.rpt_res   = rpt_res_q;
    assign bus.rpt_len   = rpt_len_q;
    assign bus.rpt_sat   = rpt_sat_q;

endmodule

// File: tb/tb_symbol_residue_tracker.sv
// Bench for symbol_residue_tracker: occurrence-count reference model checked
// every cycle, directed frames with literal expectations, randomized traffic.
module tb_symbol_residue_tracker;

    localparam int SW   = 2;
    localparam int M    = 3;
    localparam int LW   = 3;
    localparam int NS   = 4;
    localparam int LMAX = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    symbol_residue_tracker_if #(.SYM_W(SW), .MOD(M), .LEN_W(LW)) bus ();
    symbol_residue_tracker_if #(.SYM_W(1), .MOD(2), .LEN_W(16)) pbus ();

    symbol_residue_tracker #(.SYM_W(SW), .MOD(M), .LEN_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    symbol_residue_tracker #(.SYM_W(1), .MOD(2), .LEN_W(16)) dut_p (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pbus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw occurrence counts and true frame length.
    int occ [NS];
    int flen;
    bit m_hold, m_rv, m_rsat;
    int m_rres [NS];
    int m_rlen;

    function automatic logic [7:0] flat_of(input int c [NS]);
        logic [7:0] f;
        logic [1:0] r;
        f = '0;
        for (int i = 0; i < NS; i++) begin
            r = 2'(c[i] % M);
            f[i*2 +: 2] = r;
        end
        return f;
    endfunction

    function automatic logic [3:0] zero_of(input int c [NS]);
        logic [3:0] z;
        for (int i = 0; i < NS; i++) z[i] = ((c[i] % M) == 0);
        return z;
    endfunction

    task automatic model_reset_live();
        for (int i = 0; i < NS; i++) occ[i] = 0;
        flen = 0;
    endtask

    initial begin
        model_reset_live();
        for (int i = 0; i < NS; i++) m_rres[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset_live();
                m_hold = 0; m_rv = 0; m_rsat = 0; m_rlen = 0;
                for (int i = 0; i < NS; i++) m_rres[i] = 0;
            end else begin
                bit acc;
                acc = bus.in_valid && !m_hold && !bus.clear;
                if (bus.clear) model_reset_live();
                if (m_hold) begin
                    if (bus.rpt_ready) begin m_hold = 0; m_rv = 0; end
                end else if (acc) begin
                    occ[int'(bus.in_sym)]++;
                    flen++;
                    if (bus.in_last) begin
                        for (int i = 0; i < NS; i++) m_rres[i] = occ[i];
                        m_rlen = (flen > LMAX) ? LMAX : flen;
                        m_rsat = (flen > LMAX);
                        m_hold = 1; m_rv = 1;
                        model_reset_live();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready", bus.in_ready, !m_hold && !bus.clear);
                check("res_flat", bus.res_flat, flat_of(occ));
                check("mod_zero", bus.mod_zero, zero_of(occ));
                check("rpt_valid", bus.rpt_valid, m_rv);
                if (m_rv) begin
                    check("rpt_res", bus.rpt_res, flat_of(m_rres));
                    check("rpt_zero", bus.rpt_zero, zero_of(m_rres));
                    check("rpt_len", bus.rpt_len, m_rlen);
                    check("rpt_sat", bus.rpt_sat, m_rsat);
                end
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic l);
        bit got;
        got = 0;
        bus.in_valid = 1; bus.in_sym = s; bus.in_last = l;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 0; bus.in_last = 0;
        if (!got) begin
            n_checks++; n_err++;
            $display("FAIL send_timeout: got no in_ready expected in_ready within 50 cycles");
        end
    endtask

    task automatic pulse_ready();
        bus.rpt_ready = 1;
        @(posedge clk); #1;
        bus.rpt_ready = 0;
    endtask

    initial begin
        bus.clear = 0; bus.in_valid = 0; bus.in_sym = '0; bus.in_last = 0; bus.rpt_ready = 0;
        pbus.clear = 0; pbus.in_valid = 0; pbus.in_sym = '0; pbus.in_last = 0; pbus.rpt_ready = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        #1;
        check("rst_ready", bus.in_ready, 1);
        check("rst_zero", bus.mod_zero, 4'hf);
        check("rst_flat", bus.res_flat, 0);
        check("rst_rv", bus.rpt_valid, 0);
        check("rst_len", bus.rpt_len, 0);
        @(posedge clk); #1;

        // Parity: 1,0,1,1 -> zeros=1, ones=3.
        pbus.in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            pbus.in_sym = (k == 1) ? 1'b0 : 1'b1;
            pbus.in_last = (k == 3);
            @(posedge clk); #1;
            if (k == 1) begin
                check("par_mid_flat", pbus.res_flat, 2'b11);
                check("par_mid_zero", pbus.mod_zero, 2'b00);
            end
        end
        pbus.in_valid = 0; pbus.in_last = 0;
        check("par_rv", pbus.rpt_valid, 1);
        check("par_res", pbus.rpt_res, 2'b11);
        check("par_zero", pbus.rpt_zero, 2'b00);
        check("par_len", pbus.rpt_len, 4);
        check("par_live", pbus.mod_zero, 2'b11);

        // Modulo wrap: symbol 2 seven times, 7 mod 3 = 1.
        for (int k = 0; k < 7; k++) send(2'd2, k == 6);
        check("wrap_rv", bus.rpt_valid, 1);
        check("wrap_res", bus.rpt_res, 8'h10);
        check("wrap_zero", bus.rpt_zero, 4'b1011);
        check("wrap_len", bus.rpt_len, 7);
        check("wrap_sat", bus.rpt_sat, 0);
        check("wrap_live", bus.res_flat, 0);

        // Backpressure with a symbol offered throughout.
        bus.in_valid = 1; bus.in_sym = 2'd1; bus.in_last = 0;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready", bus.in_ready, 0);
            check("bp_len", bus.rpt_len, 7);
        end
        @(posedge clk); #1;
        bus.rpt_ready = 1;
        @(posedge clk); #1;
        bus.rpt_ready = 0;
        check("bp_drop", bus.rpt_valid, 0);
        @(posedge clk); #1;
        bus.in_valid = 0;
        check("bp_accept", bus.res_flat, 8'h04);

        // Clear in RUN drops the offered symbol; clear in HOLD keeps the report.
        send(2'd0, 0);
        send(2'd3, 0);
        check("clr_pre", bus.res_flat, 8'h45);
        bus.clear = 1; bus.in_valid = 1; bus.in_sym = 2'd3;
        @(negedge clk);
        check("clr_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.clear = 0; bus.in_valid = 0;
        check("clr_flat", bus.res_flat, 0);
        check("clr_zero", bus.mod_zero, 4'hf);
        send(2'd1, 1);
        bus.clear = 1;
        @(posedge clk); #1;
        bus.clear = 0;
        check("hclr_rv", bus.rpt_valid, 1);
        check("hclr_len", bus.rpt_len, 1);
        check("hclr_res", bus.rpt_res, 8'h04);
        check("hclr_zero", bus.rpt_zero, 4'b1101);
        pulse_ready();

        // Saturation: 10 symbols 0,1,2,3,... -> counts 3,3,2,2.
        for (int k = 0; k < 10; k++) send(2'(k % 4), k == 9);
        check("sat_len", bus.rpt_len, 7);
        check("sat_sat", bus.rpt_sat, 1);
        check("sat_res", bus.rpt_res, 8'hA0);
        check("sat_zero", bus.rpt_zero, 4'b0011);
        pulse_ready();
        send(2'd3, 0);
        send(2'd3, 1);
        check("post_len", bus.rpt_len, 2);
        check("post_sat", bus.rpt_sat, 0);
        check("post_res", bus.rpt_res, 8'h80);
        pulse_ready();

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_sym    = 2'($urandom);
            bus.in_last   = ($urandom % 6) == 0;
            bus.rpt_ready = ($urandom % 3) == 0;
            bus.clear     = ($urandom % 20) == 0;
            @(posedge clk); #1;
        end
        bus.in_valid = 0; bus.in_last = 0; bus.clear = 0; bus.rpt_ready = 1;
        repeat (2) @(posedge clk);
        #1 bus.rpt_ready = 0;

        // Asynchronous reset in the middle of a frame.
        pbus.rpt_ready = 1;
        @(posedge clk); #1;
        pbus.rpt_ready = 0;
        pbus.in_valid = 1; pbus.in_sym = 1'b1;
        @(posedge clk); #1;
        pbus.in_valid = 0;
        check("pre_rst_zero", pbus.mod_zero, 2'b01);
        send(2'd1, 0);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check("arst_p_zero", pbus.mod_zero, 2'b11);
        check("arst_p_flat", pbus.res_flat, 0);
        check("arst_p_rv", pbus.rpt_valid, 0);
        check("arst_p_ready", pbus.in_ready, 1);
        check("arst_flat", bus.res_flat, 0);
        check("arst_ready", bus.in_ready, 1);
        @(posedge clk); #2;
        rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
